rename_issue_queue: RTL

//   Out-of-order issue queue directly downstream of the renaming register file.

---
 rtl/rename_issue_queue_pkg.sv | 42 ++++
 rtl/rename_issue_queue_if.sv | 50 +++++
 rtl/rename_issue_queue_preg_scoreboard.sv | 57 +++++
 rtl/rename_issue_queue.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rename_issue_queue_pkg.sv
// ---------------------------------------------------------------------------
// rename_issue_queue_pkg
//   Shared sizing constants, the queue entry record and a wakeup-match helper
//   for the out-of-order issue queue that sits behind the renaming stage.
//   No ports (package).
// ---------------------------------------------------------------------------
package rename_issue_queue_pkg;

  localparam int PREG_ADDR_WIDTH = 6;
  localparam int FREE_LIST_WIDTH = 3;
  localparam int IQ_DEPTH        = 4;
  localparam int PAYLOAD_WIDTH   = 32;

  localparam int NUM_PREGS = 1 << PREG_ADDR_WIDTH;
  localparam int CNT_WIDTH = $clog2(IQ_DEPTH + 1);
  localparam int IDX_WIDTH = $clog2(IQ_DEPTH);

  typedef logic [PREG_ADDR_WIDTH-1:0] preg_t;
  typedef logic [FREE_LIST_WIDTH-1:0] al_idx_t;
  typedef logic [PAYLOAD_WIDTH-1:0]   payload_t;

  // One queue slot: the renamed instruction plus per-source readiness.
  typedef struct packed {
    payload_t payload;
    preg_t    prs;
    preg_t    prt;
    preg_t    prd;
    logic     rd_valid;
    al_idx_t  al_index;
    logic     prs_ready;
    logic     prt_ready;
  } iq_entry_t;

  // True when a write-back broadcast produces the given source tag.
  // Tag 0 is the hardwired zero register and is never broadcast.
  function automatic logic wb_hits(input logic  wb_valid,
                                   input preg_t wb_preg,
                                   input preg_t tag);
    return wb_valid && (wb_preg != '0) && (wb_preg == tag);
  endfunction

endpackage

// File: rtl/rename_issue_queue_if.sv
// ---------------------------------------------------------------------------
// rename_issue_queue_if
//   Bundles the rename-side enqueue handshake, the write-back broadcast, the
//   flush request and the execute-side issue handshake.
//   master : renaming/execute environment (drives enq_*, wb_*, flush, iss_ready)
//   slave  : the issue queue (drives enq_ready, stall_out, iss_*)
// ---------------------------------------------------------------------------
interface rename_issue_queue_if;
  import rename_issue_queue_pkg::*;

  logic     flush;

  logic     enq_valid;
  logic     enq_ready;
  payload_t enq_payload;
  preg_t    enq_prs;
  preg_t    enq_prt;
  preg_t    enq_prd;
  logic     enq_rd_valid;
  al_idx_t  enq_al_index;

  logic     wb_valid;
  preg_t    wb_preg;

  logic     iss_valid;
  logic     iss_ready;
  payload_t iss_payload;
  preg_t    iss_prs;
  preg_t    iss_prt;
  preg_t    iss_prd;
  logic     iss_rd_valid;
  al_idx_t  iss_al_index;

  logic     stall_out;

  modport master (
    output flush, enq_valid, enq_payload, enq_prs, enq_prt, enq_prd,
           enq_rd_valid, enq_al_index, wb_valid, wb_preg, iss_ready,
    input  enq_ready, stall_out, iss_valid, iss_payload, iss_prs, iss_prt,
           iss_prd, iss_rd_valid, iss_al_index
  );

  modport slave (
    input  flush, enq_valid, enq_payload, enq_prs, enq_prt, enq_prd,
           enq_rd_valid, enq_al_index, wb_valid, wb_preg, iss_ready,
    output enq_ready, stall_out, iss_valid, iss_payload, iss_prs, iss_prt,
           iss_prd, iss_rd_valid, iss_al_index
  );

endinterface

// File: rtl/rename_issue_queue_preg_scoreboard.sv
// ---------------------------------------------------------------------------
// rename_issue_queue_preg_scoreboard
//   Busy bit per physical register. A set marks a tag as having an in-flight
//   producer, a clear (write-back) releases it. Two combinational read ports
//   report source readiness, including a bypass of the same-cycle clear.
// Ports
//   clk, rst_n            clock, async active-low reset
//   flush_i               clear every busy bit
//   set_valid_i/set_tag_i mark tag busy (new producer enqueued)
//   clr_valid_i/clr_tag_i mark tag free (write-back broadcast)
//   rd_a_tag_i/rd_b_tag_i source tags to look up
//   rd_a_ready_o/rd_b_ready_o  source ready
// ---------------------------------------------------------------------------
module rename_issue_queue_preg_scoreboard
  import rename_issue_queue_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush_i,
  input  logic  set_valid_i,
  input  preg_t set_tag_i,
  input  logic  clr_valid_i,
  input  preg_t clr_tag_i,
  input  preg_t rd_a_tag_i,
  input  preg_t rd_b_tag_i,
  output logic  rd_a_ready_o,
  output logic  rd_b_ready_o
);

  logic [NUM_PREGS-1:0] busy_q;
  logic [NUM_PREGS-1:0] busy_d;

  // Set is applied after clear so a new producer wins over a same-cycle
  // write-back of the old one; tag 0 is forced free.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (clr_valid_i) busy_d[clr_tag_i] = 1'b0;
      if (set_valid_i) busy_d[set_tag_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Readiness bypasses the write-back of this very cycle.
  assign rd_a_ready_o = (rd_a_tag_i == '0) || !busy_q[rd_a_tag_i] ||
                        (clr_valid_i && (clr_tag_i == rd_a_tag_i));
  assign rd_b_ready_o = (rd_b_tag_i == '0) || !busy_q[rd_b_tag_i] ||
                        (clr_valid_i && (clr_tag_i == rd_b_tag_i));

endmodule

// File: rtl/rename_issue_queue.sv
// ---------------------------------------------------------------------------
// rename_issue_queue
//   Collapsing out-of-order issue queue. Slot 0 is the oldest entry and valid
//   slots are contiguous from 0. The oldest entry with both sources ready is
//   presented on iss_*; when it is accepted the younger slots shift down.
//   Write-back broadcasts wake waiting sources; flush empties the queue and
//   clears the scoreboard.
// Ports
//   clk, rst_n   clock, async active-low reset
//   bus_if       slave side of rename_issue_queue_if (enq_*, wb_*, flush,
//                iss_*, stall_out)
// ---------------------------------------------------------------------------
module rename_issue_queue
  import rename_issue_queue_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  rename_issue_queue_if.slave  bus_if
);

  iq_entry_t            slots_q [IQ_DEPTH];
  iq_entry_t            slots_d [IQ_DEPTH];
  iq_entry_t            woken   [IQ_DEPTH+1];
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic [CNT_WIDTH-1:0] count_after;

  logic                 enq_ready;
  logic                 fire_enq;
  logic                 fire_iss;
  logic                 wb_clear;
  logic                 sb_set;
  logic                 new_prs_ready;
  logic                 new_prt_ready;
  iq_entry_t            new_entry;

  logic                 sel_found;
  logic [IDX_WIDTH-1:0] sel_idx;
  iq_entry_t            sel_entry;

  // An issuing slot is not reclaimed in the same cycle, so enq_ready depends
  // only on the registered occupancy.
  assign enq_ready        = (count_q != CNT_WIDTH'(IQ_DEPTH));
  assign bus_if.enq_ready = enq_ready;
  assign bus_if.stall_out = !enq_ready;

  assign fire_enq = bus_if.enq_valid && enq_ready;
  assign fire_iss = sel_found && bus_if.iss_ready;
  assign wb_clear = bus_if.wb_valid && (bus_if.wb_preg != '0);
  assign sb_set   = fire_enq && bus_if.enq_rd_valid && (bus_if.enq_prd != '0);

  rename_issue_queue_preg_scoreboard u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (bus_if.flush),
    .set_valid_i  (sb_set),
    .set_tag_i    (bus_if.enq_prd),
    .clr_valid_i  (wb_clear),
    .clr_tag_i    (bus_if.wb_preg),
    .rd_a_tag_i   (bus_if.enq_prs),
    .rd_b_tag_i   (bus_if.enq_prt),
    .rd_a_ready_o (new_prs_ready),
    .rd_b_ready_o (new_prt_ready)
  );

  always_comb begin
    new_entry           = '0;
    new_entry.payload   = bus_if.enq_payload;
    new_entry.prs       = bus_if.enq_prs;
    new_entry.prt       = bus_if.enq_prt;
    new_entry.prd       = bus_if.enq_prd;
    new_entry.rd_valid  = bus_if.enq_rd_valid;
    new_entry.al_index  = bus_if.enq_al_index;
    new_entry.prs_ready = new_prs_ready;
    new_entry.prt_ready = new_prt_ready;
  end

  // Priority encoder: lowest occupied slot with both sources ready.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_entry = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (!sel_found && (CNT_WIDTH'(i) < count_q) &&
          slots_q[i].prs_ready && slots_q[i].prt_ready) begin
        sel_found = 1'b1;
        sel_idx   = IDX_WIDTH'(i);
        sel_entry = slots_q[i];
      end
    end
  end

  assign bus_if.iss_valid    = sel_found;
  assign bus_if.iss_payload  = sel_entry.payload;
  assign bus_if.iss_prs      = sel_entry.prs;
  assign bus_if.iss_prt      = sel_entry.prt;
  assign bus_if.iss_prd      = sel_entry.prd;
  assign bus_if.iss_rd_valid = sel_entry.rd_valid;
  assign bus_if.iss_al_index = sel_entry.al_index;

  // Next state: wake sources, collapse over the issued slot, then append the
  // new entry at the post-collapse tail. woken[IQ_DEPTH] is an empty filler
  // shifted into the top slot.
  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      woken[i] = slots_q[i];
      if (wb_hits(bus_if.wb_valid, bus_if.wb_preg, slots_q[i].prs))
        woken[i].prs_ready = 1'b1;
      if (wb_hits(bus_if.wb_valid, bus_if.wb_preg, slots_q[i].prt))
        woken[i].prt_ready = 1'b1;
    end
    woken[IQ_DEPTH] = '0;

    count_after = count_q - CNT_WIDTH'(fire_iss);
    count_d     = count_after + CNT_WIDTH'(fire_enq);

    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (fire_iss && (IDX_WIDTH'(i) >= sel_idx))
        slots_d[i] = woken[i+1];
      else
        slots_d[i] = woken[i];
      if (fire_enq && (CNT_WIDTH'(i) == count_after))
        slots_d[i] = new_entry;
    end

    if (bus_if.flush) begin
      count_d = '0;
      for (int i = 0; i < IQ_DEPTH; i++) slots_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) slots_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < IQ_DEPTH; i++) slots_q[i] <= slots_d[i];
    end
  end

endmodule
